// File: rtl/synchro_counter_n_bit_pkg.sv
// synchro_counter_pkg: mode encodings and modulus helper shared by the synchro counters
package synchro_counter_pkg;
  localparam logic [1:0] MODE_WRAP = 2'b00;
  localparam logic [1:0] MODE_SAT = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  function automatic logic [32:0] limit_top(input logic [31:0] limit, input int unsigned width);
    return (limit == 32'd0) ? ((33'd1 << width) - 33'd1) : ({1'b0, limit} - 33'd1);
  endfunction
endpackage

// File: rtl/synchro_counter_n_bit_rising_edge_detect.sv
// rising_edge_detect: one-flop rising edge detector; the flop tracks the input even in reset
module rising_edge_detect (
  input  logic qzt_clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);
  logic sig_d;
  always_ff @(posedge qzt_clk) sig_d <= sig;
  assign rise = sig & ~sig_d & ~reset;
endmodule

// File: rtl/synchro_counter_n_bit.sv
// synchro_counter_n_bit: programmable-modulus up/down counter of clk_in rising edges
module synchro_counter_n_bit
  import synchro_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             qzt_clk,
  input  logic             reset,
  input  logic             clk_in,
  input  logic             set,
  input  logic [WIDTH-1:0] preset_value,
  input  logic [WIDTH-1:0] limit,
  input  logic             up_down,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             borrow,
  output logic             terminal,
  output logic             done
);
  logic tick;
  logic [32:0] top, out_x;
  logic at_top, at_zero;
  rising_edge_detect u_edge (
    .qzt_clk(qzt_clk),
    .reset(reset),
    .sig(clk_in),
    .rise(tick)
  );
  assign top = limit_top(32'(limit), WIDTH);
  assign out_x = 33'(out);
  assign at_top = out_x >= top;
  assign at_zero = out == '0;
  assign terminal = up_down ? (out_x == top) : at_zero;
  always_ff @(posedge qzt_clk)
    if (reset) begin
      out <= '0;
      carry <= 1'b0;
      borrow <= 1'b0;
      done <= 1'b0;
    end else if (set) begin
      out <= preset_value;
      carry <= 1'b0;
      borrow <= 1'b0;
      done <= 1'b0;
    end else begin
      carry <= 1'b0;
      borrow <= 1'b0;
      if (tick && !done) begin
        if (up_down) begin
          if (!at_top) out <= out + WIDTH'(1);
          else if (mode == MODE_SAT) out <= top[WIDTH-1:0];
          else begin
            out <= '0;
            carry <= 1'b1;
            done <= mode == MODE_ONESHOT;
          end
        end else begin
          if (!at_zero) out <= (out_x > top) ? top[WIDTH-1:0] : out - WIDTH'(1);
          else if (mode != MODE_SAT) begin
            out <= top[WIDTH-1:0];
            borrow <= 1'b1;
            done <= mode == MODE_ONESHOT;
          end
        end
      end
    end
endmodule

// File: tb/tb_synchro_counter_n_bit.sv
// tb_synchro_counter_n_bit: scoreboard bench with directed plan scenarios and random traffic
module tb_synchro_counter_n_bit;
  localparam int W = 8;
  logic qzt_clk = 1'b0;
  logic reset = 1'b1, clk_in = 1'b0, set = 1'b0, up_down = 1'b1;
  logic [W-1:0] preset_value = '0, limit = '0;
  logic [1:0] mode = 2'b00;
  logic [W-1:0] out;
  logic carry, borrow, terminal, done;
  logic n_reset = 1'b1, n_clk_in = 1'b0, n_set = 1'b0, n_ud = 1'b1;
  logic [W-1:0] n_preset = '0, n_limit = '0;
  logic [1:0] n_mode = 2'b00;
  typedef struct packed {
    logic [W-1:0] out;
    logic carry, borrow, done, terminal;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int m_cnt = 0;
  bit m_prev = 0, m_c = 0, m_b = 0, m_d = 0;
  bit finished = 0;

  synchro_counter_n_bit #(.WIDTH(W)) dut (
    .qzt_clk(qzt_clk), .reset(reset), .clk_in(clk_in), .set(set),
    .preset_value(preset_value), .limit(limit), .up_down(up_down), .mode(mode),
    .out(out), .carry(carry), .borrow(borrow), .terminal(terminal), .done(done)
  );

  always #5 qzt_clk = ~qzt_clk;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: the count lives in 0..range-1, range being limit or 2^W for limit 0.
  task automatic step();
    int range;
    bit tk;
    exp_t e;
    @(negedge qzt_clk);
    reset = n_reset; set = n_set; clk_in = n_clk_in; preset_value = n_preset;
    limit = n_limit; up_down = n_ud; mode = n_mode;
    range = (n_limit == 0) ? (1 << W) : int'(n_limit);
    tk = n_clk_in && !m_prev;
    m_prev = n_clk_in;
    if (n_reset) begin m_cnt = 0; m_c = 0; m_b = 0; m_d = 0; end
    else if (n_set) begin m_cnt = int'(n_preset); m_c = 0; m_b = 0; m_d = 0; end
    else begin
      m_c = 0; m_b = 0;
      if (tk && !m_d) begin
        if (n_ud) begin
          if (m_cnt + 1 < range) m_cnt++;
          else if (n_mode == 2'b01) m_cnt = range - 1;
          else begin m_cnt = 0; m_c = 1; m_d = (n_mode == 2'b10); end
        end else if (m_cnt == 0) begin
          if (n_mode != 2'b01) begin m_cnt = range - 1; m_b = 1; m_d = (n_mode == 2'b10); end
        end else m_cnt = (m_cnt >= range) ? range - 1 : m_cnt - 1;
      end
    end
    e.out = W'(m_cnt);
    e.carry = m_c;
    e.borrow = m_b;
    e.done = m_d;
    e.terminal = n_ud ? (m_cnt == range - 1) : (m_cnt == 0);
    q.push_back(e);
  endtask

  task automatic tick(int n);
    for (int i = 0; i < n; i++) begin
      n_clk_in = 1; step();
      n_clk_in = 0; step();
    end
  endtask

  task automatic do_reset();
    n_reset = 1; step(); n_reset = 0;
  endtask

  task automatic do_set(int v);
    n_preset = W'(v); n_set = 1; step(); n_set = 0;
  endtask

  initial begin : monitor
    exp_t e;
    while (!finished) begin
      @(posedge qzt_clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out", int'(out), int'(e.out));
        chk("carry", int'(carry), int'(e.carry));
        chk("borrow", int'(borrow), int'(e.borrow));
        chk("done", int'(done), int'(e.done));
        chk("terminal", int'(terminal), int'(e.terminal));
      end
    end
  end

  initial begin : driver
    int budget;
    n_limit = 10; n_ud = 1; n_mode = 2'b00;
    do_reset(); tick(25);
    n_limit = 0; do_set(254); tick(3);
    n_limit = 10; n_ud = 0; do_reset(); tick(2); do_set(200); tick(1);
    n_limit = 5; n_ud = 1; n_mode = 2'b01; do_reset(); tick(8);
    n_ud = 0; tick(5);
    n_limit = 4; n_ud = 1; n_mode = 2'b10; do_reset(); tick(6); do_set(2); step();
    n_mode = 2'b00; n_limit = 10;
    n_clk_in = 1; n_preset = 6; n_set = 1; step(); n_set = 0; n_clk_in = 0; step();
    n_reset = 1; step(); n_clk_in = 1; step(); step(); n_reset = 0; step(); step();
    n_clk_in = 0; step(); tick(7); do_reset(); step();
    for (int i = 0; i < 3000; i++) begin
      n_reset = ($urandom_range(0, 63) == 0);
      n_set = ($urandom_range(0, 15) == 0);
      n_clk_in = $urandom_range(0, 1);
      n_preset = W'($urandom);
      if ($urandom_range(0, 31) == 0) n_limit = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
      if ($urandom_range(0, 15) == 0) n_ud = $urandom_range(0, 1);
      if ($urandom_range(0, 31) == 0) n_mode = 2'($urandom_range(0, 3));
      step();
    end
    budget = 0;
    while (q.size() > 0 && budget < 10) begin @(posedge qzt_clk); #2; budget++; end
    chk("drain", q.size(), 0);
    finished = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
